// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a gate under test and checks its output.
// Optional STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_tt_sequencer #(
    parameter int unsigned            N_IN        = 2,
    parameter int unsigned            HOLD_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0]   EXP_TT      = 4'b1110
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned EW = N_IN + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [N_IN-1:0]   r_vec;
    logic [HW-1:0]     r_hold;
    logic [N_IN-1:0]   r_dut_in;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [EW-1:0]     r_err_count;
    logic [N_IN-1:0]   r_first_fail_vec;
    logic              r_first_fail_valid;

    logic              w_mis;
    logic              w_last;
    logic              w_finish;
    logic [EW-1:0]     w_err_next;

    // Compare against the expected table; only meaningful while in SAMPLE
    assign w_mis      = (dut_out != EXP_TT[r_vec]);
    assign w_last     = (r_vec == {N_IN{1'b1}});
    assign w_err_next = r_err_count + EW'(w_mis);
`ifdef STOP_ON_FAIL_EN
    assign w_finish   = w_last || w_mis;
`else
    assign w_finish   = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_vec              <= '0;
            r_hold             <= '0;
            r_dut_in           <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state            <= S_SETTLE;
                        r_vec              <= '0;
                        r_hold             <= '0;
                        r_dut_in           <= '0;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_pass             <= 1'b0;
                        r_err_count        <= '0;
                        r_first_fail_vec   <= '0;
                        r_first_fail_valid <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_hold == HW'(HOLD_CYCLES - 1)) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (w_mis) begin
                        r_err_count <= w_err_next;
                        if (!r_first_fail_valid) begin
                            r_first_fail_vec   <= r_vec;
                            r_first_fail_valid <= 1'b1;
                        end
                    end
                    if (w_finish) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= (w_err_next == '0);
                        r_dut_in <= '0;
                    end else begin
                        r_state  <= S_SETTLE;
                        r_vec    <= r_vec + N_IN'(1);
                        r_dut_in <= r_vec + N_IN'(1);
                        r_hold   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dut_in           = r_dut_in;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer (default parameters, 2-input OR table).
module tb_gate_tt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;
    logic       first_fail_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;    // 0: OR gate, 1: stuck at 0, 2: AND gate

    gate_tt_sequencer u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dut_in           (dut_in),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = |dut_in;
            1:       dut_out = 1'b0;
            default: dut_out = &dut_in;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start at edge 0, optionally re-pulse start at pulse_edge, check results at done_edge
    task automatic sweep(input int m, input int pulse_edge, input int done_edge,
                         input int e_err, input int e_ffv, input int e_ffval, input int e_pass);
        mode = m;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_done_clr", 32'(done), 0);
        check("start_pass_clr", 32'(pass), 0);
        check("start_err_clr", 32'(err_count), 0);
        check("start_ffval_clr", 32'(first_fail_valid), 0);
        check("start_dut_in", 32'(dut_in), 0);
        if (pulse_edge == 1) start = 1'b1;
        for (int e = 1; e < done_edge; e++) begin
            @(negedge clk);
            start = 1'b0;
            check("sweep_done_low", 32'(done), 0);
            check("sweep_busy", 32'(busy), 1);
            check("sweep_dut_in", 32'(dut_in), 32'(e / 2));
            if (e == pulse_edge - 1) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int h = 0; h < 2; h++) begin
            check("end_done", 32'(done), 1);
            check("end_busy", 32'(busy), 0);
            check("end_pass", 32'(pass), 32'(e_pass));
            check("end_err", 32'(err_count), 32'(e_err));
            check("end_ffv", 32'(first_fail_vec), 32'(e_ffv));
            check("end_ffval", 32'(first_fail_valid), 32'(e_ffval));
            check("end_dut_in", 32'(dut_in), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_dut_in", 32'(dut_in), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        sweep(0, 0, 8, 0, 0, 0, 1);
`ifdef STOP_ON_FAIL_EN
        sweep(1, 0, 4, 1, 1, 1, 0);
        sweep(2, 0, 4, 1, 1, 1, 0);
`else
        sweep(1, 0, 8, 3, 1, 1, 0);
        sweep(2, 0, 8, 2, 1, 1, 0);
`endif
        // Accepted from DONE with stale errors; extra pulse at edge 3 must be ignored
        sweep(0, 3, 8, 0, 0, 0, 1);

        // Reset mid-sweep while vector 10 is driven
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_dut_in", 32'(dut_in), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dut_in", 32'(dut_in), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_pass", 32'(pass), 0);
        check("mid_rst_err", 32'(err_count), 0);
        check("mid_rst_ffv", 32'(first_fail_vec), 0);
        check("mid_rst_ffval", 32'(first_fail_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);
        check("post_rst_dut_in", 32'(dut_in), 0);
        sweep(0, 0, 8, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
